// File: rtl/ff_bit_source.sv
// ff_bit_source: drains ping-pong nibble buffer banks on rx_toggle events, exposes the frame ID and serialises the payload LSB-first per ff_en
module ff_bit_source #(
  parameter int FRAMEID_LEN = 8,
  parameter int PAYLOAD_LEN = 1056,
  parameter int IDX_W = 9
) (
  input  logic                   ff_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rx_toggle,
  output logic [IDX_W:0]         rd_addr,
  input  logic [3:0]             rd_data,
  input  logic                   ff_en,
  output logic                   ff_data,
  output logic                   ff_valid,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic [FRAMEID_LEN-1:0] frameid,
  output logic                   overrun
);
  localparam int NID = FRAMEID_LEN / 4;
  localparam int CW = $clog2(PAYLOAD_LEN);
  localparam int KW = $clog2(NID + 1);
  typedef enum logic [1:0] {IDLE, ID, LOAD, SEND} state_t;
  state_t st, st_nx;
  logic s1, s2, s3, evt, take, bank, pend_vld, pend_bank, fire, last, wrap;
  logic [3:0] sh, pf;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [FRAMEID_LEN-1:0] id_sh, id_nx;
  always_ff @(posedge ff_clk) begin
    s1 <= rx_toggle;
    s2 <= s1;
    s3 <= s2;
  end
  assign evt = (s2 ^ s3) & enable & ~reset;
  assign take = (st == IDLE) && (pend_vld || evt);
  assign bank = evt ? ~s2 : pend_bank;
  assign fire = (st == SEND) && ff_en;
  assign last = cnt == CW'(PAYLOAD_LEN - 1);
  assign wrap = cnt[1:0] == 2'd3;
  assign id_nx = FRAMEID_LEN'({rd_data, id_sh} >> 4);
  always_comb begin
    st_nx = st;
    st_nx = st == IDLE ? (take ? ID : IDLE)
          : st == ID   ? (k == KW'(NID) ? LOAD : ID)
          : st == LOAD ? SEND
          : (fire && last ? IDLE : SEND);
  end
  always_ff @(posedge ff_clk) st <= reset ? IDLE : st_nx;
  always_ff @(posedge ff_clk) begin
    if (reset) begin
      rd_addr <= '0;
      ff_data <= 1'b0;
      ff_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      frameid <= '0;
      overrun <= 1'b0;
      pend_vld <= 1'b0;
      pend_bank <= 1'b0;
      sh <= '0;
      pf <= '0;
      cnt <= '0;
      k <= '0;
      id_sh <= '0;
    end else begin
      pend_vld <= take ? 1'b0 : (evt | pend_vld);
      pend_bank <= (evt && !take) ? ~s2 : pend_bank;
      overrun <= evt && pend_vld && !take;
      ff_valid <= fire;
      frame_start <= fire && cnt == '0;
      frame_end <= fire && last;
      pf <= rd_data;
      if (take) begin
        rd_addr <= {bank, {IDX_W{1'b0}}};
        k <= '0;
      end
      if (st == ID) begin
        rd_addr <= rd_addr + 1'b1;
        k <= k + 1'b1;
        if (k != '0) id_sh <= id_nx;
        if (k == KW'(NID)) frameid <= id_nx;
      end
      if (st == LOAD) begin
        sh <= rd_data;
        cnt <= '0;
      end
      if (fire) begin
        ff_data <= sh[0];
        sh <= wrap ? pf : sh >> 1;
        cnt <= cnt + 1'b1;
        if (wrap) rd_addr <= rd_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ff_bit_source.sv
// tb_ff_bit_source: table-driven frame replays plus hand sequences for pending, overrun, enable and reset corners
module tb_ff_bit_source;
  logic ff_clk, reset, enable, rx_toggle, ff_en, ff_data, ff_valid, frame_start, frame_end, overrun;
  logic [9:0] rd_addr;
  logic [3:0] rd_data;
  logic [7:0] frameid;
  logic [3:0] mem [0:1023];
  int checks = 0;
  int errors = 0;
  typedef struct {
    int hi;
    int lo;
    logic bk;
    logic [3:0] n0, n1, na, nb;
    logic [7:0] eid;
  } row_t;
  row_t rows [4];
  ff_bit_source dut (
    .ff_clk(ff_clk), .reset(reset), .enable(enable), .rx_toggle(rx_toggle),
    .rd_addr(rd_addr), .rd_data(rd_data), .ff_en(ff_en), .ff_data(ff_data),
    .ff_valid(ff_valid), .frame_start(frame_start), .frame_end(frame_end),
    .frameid(frameid), .overrun(overrun)
  );
  initial ff_clk = 1'b0;
  always #5 ff_clk = ~ff_clk;
  always @(posedge ff_clk) rd_data <= mem[rd_addr];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic fill(input logic bk, input logic [3:0] n0, n1, na, nb);
    mem[{bk, 9'd0}] = n0;
    mem[{bk, 9'd1}] = n1;
    for (int i = 0; i < 264; i++) mem[{bk, 9'(i + 2)}] = (i % 2 == 0) ? na : nb;
  endtask
  task automatic run_frame(input string nm, input int hi, lo, input logic bk, input logic [7:0] eid,
                           input logic [3:0] na, nb, input int f1, f2, exp_ov);
    int nv = 0, berr = 0, fs = -1, fe = -1, nfs = 0, nfe = 0, msb = 0, orphan = 0, ov = 0, ph = 0;
    logic [7:0] id_end = 8'h00;
    logic pen = 1'b0;
    logic [3:0] nib;
    for (int c = 0; c < 1056 * (hi + lo) + 200 && nv < 1056; c++) begin
      @(negedge ff_clk);
      if (ff_valid) begin
        nib = ((nv / 4) % 2 == 0) ? na : nb;
        if (ff_data !== nib[nv % 4]) berr++;
        if (!pen) orphan++;
        if (rd_addr[9] !== bk) msb++;
        if (frame_start) begin nfs++; fs = nv; end
        if (frame_end) begin nfe++; fe = nv; id_end = frameid; end
        nv++;
        if (nv == f1 || nv == f2) rx_toggle = ~rx_toggle;
      end else if (frame_start || frame_end) orphan++;
      if (overrun) ov++;
      pen = ph < hi;
      ff_en = pen;
      ph = (ph + 1) % (hi + lo);
    end
    chk({nm, "_bits"}, nv, 1056);
    chk({nm, "_biterr"}, berr, 0);
    chk({nm, "_startpos"}, fs, 0);
    chk({nm, "_nstart"}, nfs, 1);
    chk({nm, "_endpos"}, fe, 1055);
    chk({nm, "_nend"}, nfe, 1);
    chk({nm, "_frameid"}, int'(id_end), int'(eid));
    chk({nm, "_bank"}, msb, 0);
    chk({nm, "_orphan"}, orphan, 0);
    chk({nm, "_overrun"}, ov, exp_ov);
  endtask
  task automatic quiet(input string nm, input int n);
    int nv = 0, na = 0;
    logic [9:0] a0;
    ff_en = 1'b1;
    @(negedge ff_clk);
    a0 = rd_addr;
    for (int c = 0; c < n; c++) begin
      @(negedge ff_clk);
      if (ff_valid) nv++;
      if (rd_addr !== a0) na++;
    end
    chk({nm, "_valid"}, nv, 0);
    chk({nm, "_reads"}, na, 0);
  endtask
  task automatic chk_rst(input string nm);
    chk({nm, "_rd_addr"}, int'(rd_addr), 0);
    chk({nm, "_ff_data"}, int'(ff_data), 0);
    chk({nm, "_ff_valid"}, int'(ff_valid), 0);
    chk({nm, "_start"}, int'(frame_start), 0);
    chk({nm, "_end"}, int'(frame_end), 0);
    chk({nm, "_frameid"}, int'(frameid), 0);
    chk({nm, "_overrun"}, int'(overrun), 0);
  endtask
  initial begin
    int nv;
    rows[0] = '{hi: 1, lo: 0, bk: 1'b0, n0: 4'h5, n1: 4'hA, na: 4'h1, nb: 4'h8, eid: 8'hA5};
    rows[1] = '{hi: 1, lo: 3, bk: 1'b1, n0: 4'hC, n1: 4'h3, na: 4'h1, nb: 4'h8, eid: 8'h3C};
    rows[2] = '{hi: 2, lo: 1, bk: 1'b0, n0: 4'hF, n1: 4'h0, na: 4'h6, nb: 4'hF, eid: 8'h0F};
    rows[3] = '{hi: 3, lo: 0, bk: 1'b1, n0: 4'h2, n1: 4'hE, na: 4'hE, nb: 4'h3, eid: 8'hE2};
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    reset = 1'b1;
    enable = 1'b1;
    rx_toggle = 1'b0;
    ff_en = 1'b0;
    repeat (4) @(negedge ff_clk);
    reset = 1'b0;
    @(negedge ff_clk);
    chk_rst("reset");
    for (int r = 0; r < 4; r++) begin
      fill(rows[r].bk, rows[r].n0, rows[r].n1, rows[r].na, rows[r].nb);
      rx_toggle = ~rx_toggle;
      run_frame($sformatf("row%0d", r), rows[r].hi, rows[r].lo, rows[r].bk, rows[r].eid,
                rows[r].na, rows[r].nb, -1, -1, 0);
    end
    quiet("idle", 20);
    fill(1'b0, 4'h5, 4'hA, 4'h1, 4'h8);
    fill(1'b1, 4'hC, 4'h3, 4'h6, 4'hF);
    rx_toggle = ~rx_toggle;
    run_frame("pend_a", 1, 0, 1'b0, 8'hA5, 4'h1, 4'h8, 100, -1, 0);
    run_frame("pend_b", 1, 0, 1'b1, 8'h3C, 4'h6, 4'hF, -1, -1, 0);
    rx_toggle = ~rx_toggle;
    run_frame("ovr_a", 1, 0, 1'b0, 8'hA5, 4'h1, 4'h8, 200, 400, 1);
    run_frame("ovr_b", 1, 0, 1'b0, 8'hA5, 4'h1, 4'h8, -1, -1, 0);
    quiet("ovr_idle", 20);
    enable = 1'b0;
    rx_toggle = ~rx_toggle;
    quiet("dis", 30);
    enable = 1'b1;
    quiet("dis_after", 30);
    rx_toggle = ~rx_toggle;
    ff_en = 1'b1;
    nv = 0;
    for (int c = 0; c < 1200 && nv < 500; c++) begin
      @(negedge ff_clk);
      if (ff_valid) nv++;
    end
    chk("mid_reach", nv, 500);
    reset = 1'b1;
    @(negedge ff_clk);
    chk_rst("midrst");
    reset = 1'b0;
    quiet("post_rst", 40);
    rx_toggle = ~rx_toggle;
    run_frame("recover", 1, 0, 1'b1, 8'h3C, 4'h6, 4'hF, -1, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
